// File: rtl/pipe_front_if.sv
// Bundle between the hazard detector / fetch side and the front-end pipeline registers.
// master drives the control and fetch inputs; slave is pipe_front_regs.
interface pipe_front_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             StallF;
  logic             StallD;
  logic             FlushE;
  logic             PCSrcE;
  logic [XLEN-1:0]  PCTargetE;
  logic [31:0]      InstrF;
  logic [1:0]       ResultSrcD;
  logic             RegWriteD;
  logic             cnt_clr;

  logic [XLEN-1:0]  PCF;
  logic [31:0]      InstrD;
  logic [XLEN-1:0]  PCD;
  logic [XLEN-1:0]  PCPlus4D;
  logic             ValidD;
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [1:0]       ResultSrcE;
  logic             RegWriteE;
  logic             ValidE;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output StallF, StallD, FlushE, PCSrcE, PCTargetE, InstrF,
           ResultSrcD, RegWriteD, cnt_clr,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, Rs1D, Rs2D,
           Rs1E, Rs2E, RdE, ResultSrcE, RegWriteE, ValidE,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  StallF, StallD, FlushE, PCSrcE, PCTargetE, InstrF,
           ResultSrcD, RegWriteD, cnt_clr,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, Rs1D, Rs2D,
           Rs1E, Rs2E, RdE, ResultSrcE, RegWriteE, ValidE,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX pipeline registers driven by hazard stall/flush controls,
// with saturating stall/redirect event counters.
module pipe_front_regs #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_front_if.slave bus
);
  localparam logic [31:0]      NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0]  FOUR    = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  pcf_q;
  logic [XLEN-1:0]  pc_plus4f;
  logic [31:0]      instrd_q;
  logic [XLEN-1:0]  pcd_q;
  logic [XLEN-1:0]  pcplus4d_q;
  logic             validd_q;
  logic [4:0]       rs1e_q;
  logic [4:0]       rs2e_q;
  logic [4:0]       rde_q;
  logic [1:0]       resultsrce_q;
  logic             regwritee_q;
  logic             valide_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             flush_e_eff;

  assign pc_plus4f   = pcf_q + FOUR;
  assign flush_e_eff = bus.FlushE | bus.PCSrcE;

  // Redirect wins over a fetch stall so a taken branch is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pcf_q <= RESET_PC;
    else if (bus.PCSrcE)
      pcf_q <= bus.PCTargetE;
    else if (!bus.StallF)
      pcf_q <= pc_plus4f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrd_q   <= NOP;
      pcd_q      <= '0;
      pcplus4d_q <= '0;
      validd_q   <= 1'b0;
    end else if (bus.PCSrcE) begin
      instrd_q   <= NOP;
      pcd_q      <= '0;
      pcplus4d_q <= '0;
      validd_q   <= 1'b0;
    end else if (!bus.StallD) begin
      instrd_q   <= bus.InstrF;
      pcd_q      <= pcf_q;
      pcplus4d_q <= pc_plus4f;
      validd_q   <= 1'b1;
    end
  end

  // E has no hold: a stalled D instruction is re-issued unless bubbled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1e_q       <= '0;
      rs2e_q       <= '0;
      rde_q        <= '0;
      resultsrce_q <= '0;
      regwritee_q  <= 1'b0;
      valide_q     <= 1'b0;
    end else if (flush_e_eff) begin
      rs1e_q       <= '0;
      rs2e_q       <= '0;
      rde_q        <= '0;
      resultsrce_q <= '0;
      regwritee_q  <= 1'b0;
      valide_q     <= 1'b0;
    end else begin
      rs1e_q       <= instrd_q[19:15];
      rs2e_q       <= instrd_q[24:20];
      rde_q        <= instrd_q[11:7];
      resultsrce_q <= bus.ResultSrcD;
      regwritee_q  <= bus.RegWriteD & validd_q;
      valide_q     <= validd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.StallD && !bus.PCSrcE && stall_cnt_q != CNT_MAX)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (bus.PCSrcE && flush_cnt_q != CNT_MAX)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.PCF        = pcf_q;
  assign bus.InstrD     = instrd_q;
  assign bus.PCD        = pcd_q;
  assign bus.PCPlus4D   = pcplus4d_q;
  assign bus.ValidD     = validd_q;
  assign bus.Rs1D       = instrd_q[19:15];
  assign bus.Rs2D       = instrd_q[24:20];
  assign bus.Rs1E       = rs1e_q;
  assign bus.Rs2E       = rs2e_q;
  assign bus.RdE        = rde_q;
  assign bus.ResultSrcE = resultsrce_q;
  assign bus.RegWriteE  = regwritee_q;
  assign bus.ValidE     = valide_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
endmodule

// File: doc/pipe_front_regs.md
Name: pipe_front_regs

Overview:
- Sequential counterpart to the pipeline hazard detector: consumes its StallF/StallD/FlushE outputs and the EX-stage branch redirect.
- Applies them to the PC register, the IF/ID register and the ID/EX control/register-index register.
- Extracts Rs1D/Rs2D back to the hazard detector, closing the loop.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PCF value after reset.
- CNT_W, 32, width of each event counter.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- StallF  in  1  hold PCF.
- StallD  in  1  hold IF/ID register.
- FlushE  in  1  bubble ID/EX register.
- PCSrcE  in  1  taken branch/jump in EX; redirects PC and flushes D and E.
- PCTargetE  in  XLEN  redirect target.
- InstrF  in  32  instruction memory read data for PCF.
- ResultSrcD  in  2  decoder result-source select for instruction in D.
- RegWriteD  in  1  decoder register-write enable for instruction in D.
- cnt_clr  in  1  synchronous clear of both counters.
- PCF  out  XLEN  fetch PC.
- InstrD  out  32  decode-stage instruction.
- PCD  out  XLEN  decode-stage PC.
- PCPlus4D  out  XLEN  PCD+4.
- ValidD  out  1  D holds a real instruction.
- Rs1D  out  5  InstrD[19:15], combinational.
- Rs2D  out  5  InstrD[24:20], combinational.
- Rs1E  out  5  EX-stage rs1.
- Rs2E  out  5  EX-stage rs2.
- RdE  out  5  EX-stage rd.
- ResultSrcE  out  2  EX-stage result source.
- RegWriteE  out  1  EX-stage write enable.
- ValidE  out  1  E holds a real instruction.
- stall_cnt  out  CNT_W  cycles with an applied D stall.
- flush_cnt  out  CNT_W  redirect events.

Behaviour:
- Reset (rst_n=0, asynchronous, any cycle including mid-stall):
  - PCF=RESET_PC.
  - InstrD=32'h0000_0013 (NOP); PCD=0, PCPlus4D=0, ValidD=0.
  - Rs1E=0, Rs2E=0, RdE=0, ResultSrcE=0, RegWriteE=0, ValidE=0.
  - stall_cnt=0, flush_cnt=0.
- PC register, priority order:
  - PCSrcE: PCF<=PCTargetE.
  - else StallF: hold.
  - else PCF<=PCF+4, modulo 2^XLEN (all-ones-minus-3 wraps to 0).
  - PCSrcE overrides StallF.
- IF/ID register, priority order:
  - PCSrcE (FlushD): InstrD<=NOP, PCD<=0, PCPlus4D<=0, ValidD<=0.
  - else StallD: hold all fields.
  - else InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1.
  - Flush overrides stall.
- ID/EX register:
  - Effective flush = FlushE | PCSrcE. When asserted, all E outputs <= 0 (bubble, ValidE=0).
  - Otherwise Rs1E<=Rs1D, Rs2E<=Rs2D, RdE<=InstrD[11:7], ResultSrcE<=ResultSrcD, RegWriteE<=RegWriteD & ValidD, ValidE<=ValidD.
  - No stall input for E: a held D instruction with FlushE=0 is re-issued into E each cycle.
- Latency:
  - Instruction at PCF reaches D one cycle later and E two cycles later, absent stall or flush.
  - Redirect is visible on PCF one cycle after PCSrcE.
- Counters:
  - stall_cnt += 1 on each cycle with StallD=1 and PCSrcE=0.
  - flush_cnt += 1 on each cycle with PCSrcE=1.
  - Both saturate at all-ones and never wrap.
  - cnt_clr has priority over increment in the same cycle; result is 0.
- Rs1D/Rs2D are pure slices of the InstrD register, with no added delay, so the hazard loop stays single-cycle.

Test Plan:
- Reset release, no stalls, InstrF driven with distinct words: PCF sequence 0,4,8,12; InstrD lags one cycle, ValidD=1 from cycle 2; ValidE=1 from cycle 3.
- Load-use stall (StallF=StallD=FlushE=1 for one cycle at PCF=0x10): PCF holds 0x10 two consecutive cycles; InstrD unchanged; ValidE=0 and RegWriteE=0 for one cycle; stall_cnt=1.
- PCSrcE=1 with PCTargetE=0x100 while StallF=StallD=1: next PCF=0x100, InstrD=0x00000013, ValidD=0, ValidE=0, flush_cnt=1, stall_cnt unchanged.
- PC wrap: RESET_PC=32'hFFFF_FFFC, no stalls: PCF goes FFFF_FFFC then 0000_0000; PCPlus4D=0 when PCD=FFFF_FFFC.
- Counter saturation with CNT_W=4: hold StallD=1 for 20 cycles -> stall_cnt=15; cnt_clr=1 together with StallD=1 -> stall_cnt=0 next cycle.
- rst_n asserted mid-stall, asynchronously between clock edges: all outputs take reset values immediately, before the next edge; after release the fetch sequence restarts at RESET_PC.
